// File: rtl/mpc_row_dot_rom_reader.sv
// -----------------------------------------------------------------------------
// mpc_row_dot_rom_reader
//
// Computes one signed dot product  result = sum_{i=0..N-1} rom[i] * x[i]
// by streaming both vectors out of two synchronous-read memories
// (one-cycle read latency) in lock step.
//
// Operation: IDLE -> READ (N cycles, one address per cycle) -> DRAIN (2 cycles
// while the last product is formed and accumulated) -> DONE (1 cycle, done=1)
// -> IDLE.  start is only looked at in IDLE.
//
// Ports
//   clk           in   clock, rising edge
//   reset         in   synchronous, active-high
//   start         in   request one dot product (sampled in IDLE only)
//   idle          out  high while in IDLE
//   done          out  one-cycle pulse when result is updated
//   result        out  AccWidth signed dot product, held until the next done
//   rom_address0  out  coefficient ROM read address
//   rom_ce0       out  coefficient ROM read enable
//   rom_q0        in   coefficient ROM data (valid the cycle after ce0)
//   x_address0    out  x-vector memory read address
//   x_ce0         out  x-vector memory read enable
//   x_q0          in   x-vector data (valid the cycle after ce0)
//   dbg_state     out  current FSM state (0 IDLE, 1 READ, 2 DRAIN, 3 DONE)
//
// Handshake: there is no back-pressure.  A start seen in IDLE launches exactly
// one operation; start at any other time is dropped.  done is asserted for
// exactly one cycle and result is valid from that cycle until the next done.
// -----------------------------------------------------------------------------
module mpc_row_dot_rom_reader #(
  parameter int DataWidth    = 17,
  parameter int AddressWidth = 3,
  parameter int AddressRange = 8,
  localparam int AccWidth    = 2 * DataWidth + AddressWidth
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  output logic                    idle,
  output logic                    done,
  output logic [AccWidth-1:0]     result,
  output logic [AddressWidth-1:0] rom_address0,
  output logic                    rom_ce0,
  input  logic [DataWidth-1:0]    rom_q0,
  output logic [AddressWidth-1:0] x_address0,
  output logic                    x_ce0,
  input  logic [DataWidth-1:0]    x_q0,
  output logic [1:0]              dbg_state
);

  localparam int ProdWidth = 2 * DataWidth;
  localparam logic [AddressWidth-1:0] LastAddr = AddressWidth'(AddressRange - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                      state_q;
  logic [AddressWidth-1:0]     addr_q;
  logic                        ce_q;
  logic                        rd_v_q;    // memory data on *_q0 belongs to us this cycle
  logic                        drain_q;   // second DRAIN cycle
  logic                        done_q;
  logic signed [ProdWidth-1:0] prod_q;    // zero whenever no product is in flight
  logic signed [AccWidth-1:0]  acc_q;
  logic signed [AccWidth-1:0]  acc_d;
  logic [AccWidth-1:0]         result_q;
  logic signed [ProdWidth-1:0] prod_d;
  logic signed [AccWidth-1:0]  prod_ext;

  always_comb begin
    prod_d   = $signed(rom_q0) * $signed(x_q0);
    prod_ext = $signed({{AddressWidth{prod_q[ProdWidth-1]}}, prod_q});
    acc_d    = acc_q + prod_ext;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      ce_q     <= 1'b0;
      rd_v_q   <= 1'b0;
      drain_q  <= 1'b0;
      done_q   <= 1'b0;
      prod_q   <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      // Datapath pipeline: issue -> sample/multiply -> accumulate.
      // Data arriving when no read was issued is replaced by a zero product.
      rd_v_q <= ce_q;
      prod_q <= rd_v_q ? prod_d : '0;
      acc_q  <= acc_d;
      done_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_READ;
            ce_q    <= 1'b1;
            addr_q  <= '0;
            acc_q   <= '0;
          end
        end
        S_READ: begin
          if (addr_q == LastAddr) begin
            state_q <= S_DRAIN;
            ce_q    <= 1'b0;
            addr_q  <= '0;
            drain_q <= 1'b0;
          end else begin
            addr_q <= addr_q + 1'b1;
          end
        end
        S_DRAIN: begin
          if (drain_q) begin
            // The last product is in prod_q now; acc_d is the final sum.
            state_q  <= S_DONE;
            done_q   <= 1'b1;
            result_q <= acc_d;
          end else begin
            drain_q <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign idle         = (state_q == S_IDLE);
  assign done         = done_q;
  assign result       = result_q;
  assign rom_address0 = addr_q;
  assign x_address0   = addr_q;
  assign rom_ce0      = ce_q;
  assign x_ce0        = ce_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_mpc_row_dot_rom_reader.sv
// -----------------------------------------------------------------------------
// tb_mpc_row_dot_rom_reader
//
// Bench for mpc_row_dot_rom_reader at default parameters.  Memories are
// modelled as synchronous-read arrays that return random junk whenever no read
// is enabled.  A cycle-level reference tracks each accepted operation by its
// age in cycles and predicts every output; literal expectations pin the
// latency and known dot-product values.
// -----------------------------------------------------------------------------
module tb_mpc_row_dot_rom_reader;

  localparam int DW   = 17;
  localparam int AW   = 3;
  localparam int N    = 8;
  localparam int ACCW = 2 * DW + AW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic            idle, done, rom_ce0, x_ce0;
  logic [ACCW-1:0] result;
  logic [AW-1:0]   rom_address0, x_address0;
  logic [DW-1:0]   rom_q0, x_q0;
  logic [1:0]      dbg_state;

  mpc_row_dot_rom_reader dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .idle         (idle),
    .done         (done),
    .result       (result),
    .rom_address0 (rom_address0),
    .rom_ce0      (rom_ce0),
    .rom_q0       (rom_q0),
    .x_address0   (x_address0),
    .x_ce0        (x_ce0),
    .x_q0         (x_q0),
    .dbg_state    (dbg_state)
  );

  // ---------------- memories ----------------
  logic signed [DW-1:0] rom_mem [N];
  logic signed [DW-1:0] x_mem   [N];

  always @(posedge clk) begin
    rom_q0 <= rom_ce0 ? rom_mem[rom_address0] : DW'($urandom);
    x_q0   <= x_ce0   ? x_mem[x_address0]     : DW'($urandom);
  end

  // ---------------- counters / checker ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [ACCW-1:0] lit(input longint v);
    logic [63:0] t;
    t = v;
    return t[ACCW-1:0];
  endfunction

  function automatic logic [ACCW-1:0] dot();
    longint s;
    s = 0;
    for (int i = 0; i < N; i++) s += longint'(rom_mem[i]) * longint'(x_mem[i]);
    return lit(s);
  endfunction

  // ---------------- reference model ----------------
  // busy/age describe the operation in flight: age 1..N are the read cycles,
  // age N+3 is the done cycle, and the operation is over one cycle later.
  logic            model_on = 1'b0;
  logic            busy = 1'b0;
  int              age = 0;
  logic [ACCW-1:0] exp_res = '0;
  logic [ACCW-1:0] exp_q[$];

  always @(posedge clk) begin
    if (reset) begin
      busy     = 1'b0;
      age      = 0;
      exp_res  = '0;
      exp_q.delete();
      model_on = 1'b1;
    end else if (busy) begin
      age++;
      if (age == N + 3) exp_res = exp_q.pop_front();
      if (age == N + 4) busy = 1'b0;
    end else if (start) begin
      busy = 1'b1;
      age  = 1;
      exp_q.push_back(dot());
    end
  end

  always @(negedge clk) begin
    logic          exp_ce;
    logic [AW-1:0] exp_addr;
    if (model_on) begin
      exp_ce   = busy && (age >= 1) && (age <= N);
      exp_addr = exp_ce ? AW'(age - 1) : '0;
      chk("idle",         idle,         !busy);
      chk("done",         done,         busy && (age == N + 3));
      chk("rom_ce0",      rom_ce0,      exp_ce);
      chk("x_ce0",        x_ce0,        exp_ce);
      chk("rom_address0", rom_address0, exp_addr);
      chk("x_address0",   x_address0,   exp_addr);
      chk("result",       result,       exp_res);
    end
  end

  // ---------------- driver tasks ----------------
  // Launch one operation and wait for done; lat is cycles from start to done.
  // With noise set, start is toggled randomly while the operation runs.
  task automatic run_op(input logic noise, output int lat, output logic [ACCW-1:0] res,
                        output int n_ce, output int first_ce);
    int s0;
    logic got;
    got = 1'b0;
    lat = -1;
    res = '0;
    n_ce = 0;
    first_ce = -1;
    @(negedge clk);
    start = 1'b1;
    s0 = cyc;
    @(negedge clk);
    for (int k = 0; k < 40; k++) begin
      start = (noise && (cyc - s0) <= 10) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (rom_ce0) begin
        n_ce++;
        if (first_ce < 0) first_ce = cyc - s0;
      end
      if (done) begin
        lat = cyc - s0;
        res = result;
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    if (!got) chk("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic load_alt_rom();
    for (int i = 0; i < N; i++) rom_mem[i] = (i % 2 == 1) ? 17'h10000 : 17'h00000;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int              lat, n_ce, first_ce, n_done, s0;
    int              dcyc[$];
    logic [ACCW-1:0] res;

    for (int i = 0; i < N; i++) begin
      rom_mem[i] = '0;
      x_mem[i]   = '0;
    end

    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_idle",   idle,    1'b1);
    chk("rst_done",   done,    1'b0);
    chk("rst_ce",     rom_ce0, 1'b0);
    chk("rst_result", result,  '0);

    // Alternating ROM (odd entries = -65536), x all ones.
    load_alt_rom();
    for (int i = 0; i < N; i++) x_mem[i] = 17'sd1;
    run_op(1'b0, lat, res, n_ce, first_ce);
    chk("t1_latency", lat, 64'd11);
    chk("t1_result",  res, lit(-64'sd262144));

    // Same ROM, x[i] = i; start toggled while busy.
    for (int i = 0; i < N; i++) x_mem[i] = DW'(i);
    run_op(1'b1, lat, res, n_ce, first_ce);
    chk("t2_latency",  lat,      64'd11);
    chk("t2_result",   res,      lit(-64'sd1048576));
    chk("t2_ce_count", n_ce,     64'd8);
    chk("t2_first_ce", first_ce, 64'd1);

    // Largest magnitude: (-65536)*(-65536)*8 = 2^35.
    for (int i = 0; i < N; i++) begin
      rom_mem[i] = 17'h10000;
      x_mem[i]   = 17'h10000;
    end
    run_op(1'b0, lat, res, n_ce, first_ce);
    chk("t3_result", res, lit(64'sd34359738368));

    // start held high for 30 cycles: back-to-back operations.
    load_alt_rom();
    for (int i = 0; i < N; i++) x_mem[i] = 17'sd1;
    @(negedge clk);
    start = 1'b1;
    s0 = cyc;
    n_done = 0;
    for (int k = 0; k < 30; k++) begin
      if (done) begin
        n_done++;
        dcyc.push_back(cyc - s0);
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("t4_done_count", n_done, 64'd2);
    if (dcyc.size() == 2) begin
      chk("t4_done_first",  dcyc[0], 64'd11);
      chk("t4_done_second", dcyc[1], 64'd23);
    end
    repeat (16) @(negedge clk);
    chk("t4_result", result, lit(-64'sd262144));

    // Reset in cycle 5 of an operation.
    start = 1'b1;
    s0 = cyc;
    @(negedge clk);
    start = 1'b0;
    while (cyc - s0 < 5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t5_idle",   idle,    1'b1);
    chk("t5_ce",     rom_ce0, 1'b0);
    chk("t5_result", result,  '0);
    n_done = 0;
    for (int k = 0; k < 15; k++) begin
      if (done) n_done++;
      @(negedge clk);
    end
    chk("t5_no_done", n_done, 64'd0);
    run_op(1'b0, lat, res, n_ce, first_ce);
    chk("t5_after_result", res, lit(-64'sd262144));

    // Random contents, 1000 operations.
    for (int op = 0; op < 1000; op++) begin
      for (int i = 0; i < N; i++) begin
        rom_mem[i] = DW'($urandom_range(0, (1 << DW) - 1));
        x_mem[i]   = DW'($urandom_range(0, (1 << DW) - 1));
      end
      run_op(1'($urandom_range(0, 1)), lat, res, n_ce, first_ce);
      chk("rand_latency", lat, 64'd11);
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mpc_row_dot_rom_reader.md
MPC_ROW_DOT_ROM_READER -- requirements
Module: mpc_row_dot_rom_reader

Interface
REQ-001 SHALL provide parameter DataWidth, default 17, width of the coefficient and x words (signed two's complement).
REQ-002 SHALL provide parameter AddressWidth, default 3, width of both read addresses.
REQ-003 SHALL provide parameter AddressRange, default 8, vector length N; AddressRange <= 2**AddressWidth.
REQ-004 SHALL provide derived parameter AccWidth = 2*DataWidth+AddressWidth (37 at defaults).
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 clk  input  1  clock; all state updates on the rising edge.
REQ-007 reset  input  1  synchronous active-high reset.
REQ-008 start  input  1  request one dot product; sampled only in IDLE.
REQ-009 idle  output  1  high while in IDLE.
REQ-010 done  output  1  one-cycle pulse when result is updated.
REQ-011 result  output  AccWidth  signed sum of rom[i]*x[i], i=0..N-1.
REQ-012 rom_address0  output  AddressWidth  coefficient ROM read address.
REQ-013 rom_ce0  output  1  coefficient ROM read enable.
REQ-014 rom_q0  input  DataWidth  ROM data, valid the cycle after ce0/address.
REQ-015 x_address0  output  AddressWidth  x-vector memory read address.
REQ-016 x_ce0  output  1  x-vector memory read enable.
REQ-017 x_q0  input  DataWidth  x data, valid the cycle after ce0/address.

Function
REQ-018 SHALL implement FSM states IDLE, READ, DRAIN, DONE.
REQ-019 IDLE: start=1 -> READ next cycle; accumulator cleared; start=0 -> stay.
REQ-020 READ: lasts exactly N cycles; rom_ce0=x_ce0=1; rom_address0=x_address0=0,1,..,N-1 in successive cycles; after address N-1 -> DRAIN.
REQ-021 Outside READ: rom_ce0=x_ce0=0; rom_address0=x_address0=0.
REQ-022 Datapath: rom_q0 and x_q0 sampled one cycle after their issue cycle; full-precision signed product (2*DataWidth bits) registered; registered product added to accumulator the following cycle.
REQ-023 DRAIN: lasts 2 cycles while the last product is formed and accumulated -> DONE.
REQ-024 DONE: one cycle; done=1; result equals the final accumulator; -> IDLE.
REQ-025 Latency: start sampled in cycle 0 -> addresses issued cycles 1..N -> done=1 in cycle N+3 (cycle 11 at defaults).
REQ-026 result SHALL hold its value from a done pulse until the next done pulse, including during subsequent operations.
REQ-027 Accumulator SHALL be AccWidth bits signed; no saturation needed since overflow is impossible by width.
REQ-028 start while not in IDLE (READ, DRAIN, DONE) SHALL be ignored; no queuing.
REQ-029 Continuous start=1: a new operation SHALL begin on the IDLE cycle following DONE, giving one operation per N+4 cycles.
REQ-030 rom_q0/x_q0 values in cycles where no read was issued SHALL not affect the accumulator.

Reset
REQ-031 reset=1 SHALL force: state IDLE, idle=1, done=0, result=0, accumulator=0, product register=0, rom_ce0=x_ce0=0, addresses=0.
REQ-032 reset asserted mid-operation (any state) SHALL abort it on the next edge with no done pulse; result is 0 after reset.
REQ-033 reset has priority over start in the same cycle.

Verification
REQ-034 ROM {0,0x10000,0,0x10000,...} (odd=-65536), x all 1, start pulse at cycle 0 -> done only in cycle 11, result=-262144.
REQ-035 Same ROM, x[i]=i -> result=-65536*(1+3+5+7)=-1048576; addresses 0..7 observed with ce0=1 in cycles 1..8 only.
REQ-036 All coefficients 0x10000, x all 0x10000 (-65536) -> result=+34359738368 (2^35), no overflow.
REQ-037 start held high for 30 cycles -> done pulses at cycles 11, 23 and result stable between pulses; start pulses during READ ignored.
REQ-038 reset asserted in cycle 5 of an operation -> next cycle idle=1, ce0=0, result=0, no done; new start afterwards gives correct result.
REQ-039 Random ROM/x contents over 1000 operations -> result matches signed reference-model dot product every time.
